// File: rtl/uint_to_l3.sv
`default_nettype none
// ============================================================================
// Module   : uint_to_l3
// Brief    : Deserialises an LSB-first unsigned integer stream, subtracts the
//            forward-path offset beat by beat and packs the result into the
//            redundant L3 limb form {carry, val}.
// Revision : 1.0 - initial release
// ============================================================================
module uint_to_l3 #(
  parameter int N_LIMB  = 4,
  parameter int LIMB_W  = 68,
  parameter int CARRY_W = 4,
  parameter int BEAT_W  = 64,
  parameter logic [N_LIMB*LIMB_W+CARRY_W-1:0] OFFSET = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BEAT_W-1:0]                   in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_LIMB*(CARRY_W+LIMB_W)-1:0]  out_data,
  output logic                                err
);

  localparam int W      = N_LIMB*LIMB_W + CARRY_W;
  localparam int NBEATS = (W + BEAT_W - 1) / BEAT_W;
  localparam int ACC_W  = NBEATS*BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LO     = CARRY_W + LIMB_W;
  // Offset zero-extended to whole beats so every beat has a defined slice.
  localparam logic [ACC_W-1:0] OFFSET_EXT = ACC_W'(OFFSET);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic               borrow_nxt;
  logic               accept;
  logic               last_beat;
  logic               go_full;
  logic               unused_acc_hi;

  // Bits of the final beat above W never reach the limbs.
  assign unused_acc_hi = ^acc[ACC_W-1:W];

  // Reset forces both handshakes low so nothing transfers in the reset cycle.
  assign in_ready  = (state_q == COLLECT) && !rst;
  assign out_valid = (state_q == FULL) && !rst;

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(NBEATS-1));
  assign go_full   = accept && (in_last || last_beat);

  // Per-beat subtract with borrow; an early in_last also resolves the
  // remaining (zero) beats against the offset in the same cycle.
  always_comb begin
    logic              b;
    logic [BEAT_W-1:0] src;
    logic [BEAT_W:0]   d;
    acc_nxt = acc;
    b       = borrow;
    src     = '0;
    d       = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if ((k == int'(cnt)) || ((k > int'(cnt)) && in_last)) begin
        src = (k == int'(cnt)) ? in_data : '0;
        d   = {1'b0, src} - {1'b0, OFFSET_EXT[k*BEAT_W +: BEAT_W]}
              - {{BEAT_W{1'b0}}, b};
        acc_nxt[k*BEAT_W +: BEAT_W] = d[BEAT_W-1:0];
        b   = d[BEAT_W];
      end
    end
    borrow_nxt = b;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: fill beats, then hold until the downstream takes the word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (go_full)   state_d = FULL;
      FULL:    if (out_ready) state_d = COLLECT;
      default:                state_d = COLLECT;
    endcase
  end

  // Accumulator, beat counter, borrow chain and framing-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= accept && (in_last ^ last_beat);
      if (accept) begin
        acc <= acc_nxt;
        if (go_full) begin
          cnt    <= '0;
          borrow <= 1'b0;
        end else begin
          cnt    <= cnt + 1'b1;
          borrow <= borrow_nxt;
        end
      end
    end
  end

  // Limb packing: vals straight from R, only the top limb carries the sign bits.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_LIMB; i++) begin
      out_data[i*LO +: LIMB_W] = acc[i*LIMB_W +: LIMB_W];
    end
    out_data[(N_LIMB-1)*LO + LIMB_W +: CARRY_W] = acc[W-1 -: CARRY_W];
  end

endmodule
`default_nettype wire

// File: tb/tb_uint_to_l3.sv
`default_nettype none
// ============================================================================
// Module   : tb_uint_to_l3
// Brief    : Directed bench for uint_to_l3; two instances (OFFSET=0 and
//            OFFSET=1) share one input stream and are checked in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uint_to_l3;

  localparam logic [67:0] F68 = 68'hF_FFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  logic [63:0]  in_data;
  logic         in_ready0, in_ready1, out_valid0, out_valid1, err0, err1;
  logic [287:0] out_data0, out_data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uint_to_l3 #(.OFFSET(276'd0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .err(err0)
  );

  uint_to_l3 #(.OFFSET(276'd1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .err(err1)
  );

  typedef struct {
    logic [4:0][63:0] beats;
    int               last_idx;
    logic [287:0]     exp0;
    logic [287:0]     exp1;
    logic             exp_err;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [287:0] mk(input logic [3:0] c3, input logic [67:0] v3,
                                      input logic [67:0] v2, input logic [67:0] v1,
                                      input logic [67:0] v0);
    return {c3, v3, 4'h0, v2, 4'h0, v1, 4'h0, v0};
  endfunction

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sends n beats; in_last is raised on beat last_idx. Returns #1 after the final accept edge.
  task automatic send_beats(input logic [4:0][63:0] b, input int n, input int last_idx);
    int t;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b[k];
      in_last  = (k == last_idx);
      t = 0;
      while (!(in_ready0 && in_ready1) && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 20 cycles");
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int n;
    n = (vecs[i].last_idx < 5) ? vecs[i].last_idx + 1 : 5;
    send_beats(vecs[i].beats, n, vecs[i].last_idx);
    check($sformatf("v%0d_out_valid0", i), out_valid0, 1);
    check($sformatf("v%0d_out_valid1", i), out_valid1, 1);
    check($sformatf("v%0d_in_ready_full", i), in_ready0, 0);
    check($sformatf("v%0d_err0", i), err0, vecs[i].exp_err);
    check($sformatf("v%0d_err1", i), err1, vecs[i].exp_err);
    check($sformatf("v%0d_data0", i), out_data0, vecs[i].exp0);
    check($sformatf("v%0d_data1", i), out_data1, vecs[i].exp1);
    handshake();
    check($sformatf("v%0d_valid_drop", i), out_valid0, 0);
    check($sformatf("v%0d_err_pulse", i), err0, 0);
    check($sformatf("v%0d_ready_back", i), in_ready0, 1);
  endtask

  initial begin
    vecs[0] = '{beats: {64'h0, 64'h0, 64'h0, 64'h0, 64'h1}, last_idx: 4,
                exp0: mk(4'h0, 68'h0, 68'h0, 68'h0, 68'h1), exp1: '0, exp_err: 1'b0};
    vecs[1] = '{beats: {64'h0, 64'h0, 64'h0, 64'h10, 64'h0}, last_idx: 4,
                exp0: mk(4'h0, 68'h0, 68'h0, 68'h1, 68'h0),
                exp1: mk(4'h0, 68'h0, 68'h0, 68'h0, F68), exp_err: 1'b0};
    vecs[2] = '{beats: {64'h10000, 64'h0, 64'h0, 64'h0, 64'h0}, last_idx: 4,
                exp0: mk(4'h1, 68'h0, 68'h0, 68'h0, 68'h0),
                exp1: mk(4'h0, F68, F68, F68, F68), exp_err: 1'b0};
    vecs[3] = '{beats: {64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, last_idx: 4,
                exp0: '0, exp1: mk(4'hF, F68, F68, F68, F68), exp_err: 1'b0};
    vecs[4] = '{beats: {64'h0, 64'h0, 64'h0, 64'h7, 64'h5}, last_idx: 1,
                exp0: mk(4'h0, 68'h0, 68'h0, 68'h0, 68'h7_0000_0000_0000_0005),
                exp1: mk(4'h0, 68'h0, 68'h0, 68'h0, 68'h7_0000_0000_0000_0004), exp_err: 1'b1};
    vecs[5] = '{beats: {64'h0, 64'h0, 64'h0, 64'h0, 64'h3}, last_idx: 99,
                exp0: mk(4'h0, 68'h0, 68'h0, 68'h0, 68'h3),
                exp1: mk(4'h0, 68'h0, 68'h0, 68'h0, 68'h2), exp_err: 1'b1};
    vecs[6] = '{beats: {64'hFFFF_FFFF_FFF0_0000, 64'h0, 64'h0, 64'h0, 64'h0}, last_idx: 4,
                exp0: '0, exp1: mk(4'hF, F68, F68, F68, F68), exp_err: 1'b0};
    vecs[7] = '{beats: {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, last_idx: 4,
                exp0: mk(4'hF, F68, F68, F68, F68),
                exp1: mk(4'hF, F68, F68, F68, 68'hF_FFFF_FFFF_FFFF_FFFE), exp_err: 1'b0};
    vecs[8] = '{beats: {64'h0, 64'h0, 64'h0, 64'h0, 64'h9}, last_idx: 0,
                exp0: mk(4'h0, 68'h0, 68'h0, 68'h0, 68'h9),
                exp1: mk(4'h0, 68'h0, 68'h0, 68'h0, 68'h8), exp_err: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_err", err0, 0);
    check("rst_out_data", out_data0, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready0, 1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Backpressure: word held for 10 cycles while a beat is offered.
    send_beats(vecs[0].beats, 5, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 64'hDEAD_BEEF;
      #1;
      check($sformatf("bp%0d_valid", c), out_valid0, 1);
      check($sformatf("bp%0d_in_ready", c), in_ready0, 0);
      check($sformatf("bp%0d_data", c), out_data0, vecs[0].exp0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake();
    check("bp_ready_after_hs", in_ready0, 1);
    send_beats(vecs[1].beats, 5, 4);
    check("bp_next_valid", out_valid0, 1);
    check("bp_next_data0", out_data0, vecs[1].exp0);
    check("bp_next_data1", out_data1, vecs[1].exp1);
    handshake();

    // Reset after two beats discards the partial word.
    send_beats({64'h0, 64'h0, 64'h0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA}, 2, 99);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready0, 0);
    @(negedge clk);
    rst = 1'b0;
    send_beats(vecs[5].beats, 5, 4);
    check("midrst_valid", out_valid0, 1);
    check("midrst_err", err0, 0);
    check("midrst_data0", out_data0, vecs[5].exp0);
    check("midrst_data1", out_data1, vecs[5].exp1);

    // Reset while FULL, with out_ready high in the reset cycle.
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    check("fullrst_no_valid", out_valid0, 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    #1;
    check("fullrst_valid", out_valid0, 0);
    check("fullrst_data", out_data0, '0);
    check("fullrst_in_ready", in_ready0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uint_to_l3.md
# uint_to_l3

Deserialising converter from a plain unsigned integer into the redundant L3 polynomial form consumed by the `poly_*_L3_L3` adders. It is the inverse of the L3-to-uint path:
- accepts the integer LSB-first in fixed-width beats over a valid/ready handshake;
- subtracts the fixed offset that the forward path adds;
- splits the result into `N_LIMB` limbs of `{carry, val}`, the top limb's carry field holding the two's-complement sign bits.

It sits between the host/DMA stream and the L3 datapath input registers.

## Interface
- `N_LIMB`, 4, number of limbs (matches `ADD_DIV`)
- `LIMB_W`, 68, width of each limb's `val` field
- `CARRY_W`, 4, width of each limb's `carry` field (matches `L3_CARRY`)
- `BEAT_W`, 64, input beat width
- `OFFSET`, 0, `(N_LIMB*LIMB_W+CARRY_W)`-bit constant subtracted from the input (the offset the forward converter adds)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  one clock; reset is synchronous and active-high
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  converter can accept a beat
- `in_data`  in  `BEAT_W`  beat, LSB-first order
- `in_last`  in  1  final beat of the integer
- `out_valid`  out  1  `out_data` holds a complete L3 word
- `out_ready`  in  1  downstream accepts
- `out_data`  out  `N_LIMB*(CARRY_W+LIMB_W)`  limb i at `[i*(CARRY_W+LIMB_W) +: CARRY_W+LIMB_W]`, packed `{carry, val}`
- `err`  out  1  one-cycle pulse on a framing error

## Operation
- `W = N_LIMB*LIMB_W + CARRY_W` (276). `NBEATS = ceil(W/BEAT_W)` (5).
- Bits of the last beat above `W` are ignored.
- FSM states:
  - **COLLECT**: `in_ready=1`. Each accepted beat k computes `d = in_data - OFFSET[k*BEAT_W +: BEAT_W] - borrow`. It stores `d[BEAT_W-1:0]` into the accumulator at `k*BEAT_W`, stores the borrow-out, and increments the beat counter.
  - **FULL**: `in_ready=0`, `out_valid=1`. `out_data` is stable until the `out_ready` handshake, then the FSM returns to COLLECT with counter=0 and borrow=0.
- Limb mapping of result R (W bits, mod 2^W):
  - `val[i] = R[i*LIMB_W +: LIMB_W]`;
  - `carry[i] = 0` for `i < N_LIMB-1`;
  - `carry[N_LIMB-1] = R[W-1 -: CARRY_W]`.
  - This makes the top carry MSB the sign bit, as the L3 consumers expect.
- Leaving COLLECT for FULL:
  - On acceptance of beat `NBEATS-1`: if `in_last=0`, pulse `err`. Any following beats start a new word.
  - On acceptance of an earlier beat with `in_last=1`: pulse `err`. Remaining beats are taken as zero, with the offset subtraction and borrow still applied to them, all resolved in that same cycle.
- `err` is a pulse, never sticky.

## Timing
- Reset values: `in_ready=0` in the reset cycle, then 1. `out_valid=0`, `out_data=0`, `err=0`. State COLLECT, counter 0, borrow 0.
- `rst` asserted mid-word or while FULL discards all partial or held data. There is no output handshake in the reset cycle.
- Latency: `out_valid` rises the cycle after the final beat is accepted.
- Throughput: one word per `NBEATS+1` cycles minimum, because FULL blocks input for at least one cycle.
- `out_valid` and `out_data` hold under backpressure; `out_data` never changes while `out_valid=1`.
- `in_valid` without `in_ready` has no effect. The beat must be held by the source (AXI-stream rules).
- The borrow chain is registered per beat. There is no wide combinational subtract.

## Test plan
- OFFSET=0, input 1 (beats 1,0,0,0,0; last on beat 4) -> limb0 `{carry=0, val=1}`, all other limbs 0, `err=0`, `out_valid` the cycle after beat 4.
- OFFSET=0, input 2^68 (beat1 = 0x10) -> limb1.val=1, everything else 0. Input 2^272 (beat4 = 0x10000) -> limb3.carry=4'h1, all vals 0.
- OFFSET=1, input 0 -> every val = 68'hF_FFFF_FFFF_FFFF_FFFF, limb0-2 carry=0, limb3.carry=4'hF, `err=0`.
- Early `in_last` on beat 1 with OFFSET=0, input beats 5,7 -> `err` pulses one cycle, limb0.val = `{4'h0, 64'h7<<...}` i.e. `R = 5 + 7*2^64` (limb0.val=0x7_0000_0000_0000_0005 truncated to 68 bits, limb1.val=0), `out_valid` the next cycle.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid` -> `out_data` stable, `in_ready=0` throughout. Release -> next word accepted the cycle after the handshake.
- Assert `rst` after 2 beats, then send a full word 3 -> output is exactly 3, with no residue from the aborted beats.
